// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset core: ALU command codes, field widths
// and the bubble value of the decoded control bundle.
package core_pkg;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam int unsigned SHIFT_OP_W = 12;
  localparam int unsigned IMM24_W    = 24;
  localparam int unsigned REG_ADDR_W = 4;

  typedef struct packed {
    logic       valid;
    logic       wb_en;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  localparam ctrl_t BUBBLE = '{
    valid:     1'b0,
    wb_en:     1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    branch:    1'b0,
    s:         1'b0,
    exe_cmd:   EXE_NOP
  };

  function automatic logic mem_conflict(input logic rd, input logic wr);
    return rd & wr;
  endfunction

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register with hold > clear > load priority and
// asynchronous active-low reset to zero.
module pipe_field_reg #(
  parameter int unsigned        WIDTH   = 8,
  parameter logic [WIDTH-1:0]   CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             hold,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (!hold) begin
      if (clear) begin
        val_d = CLR_VAL;
      end else if (load) begin
        val_d = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign dout = val_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with freeze, flush and hazard-bubble handling.
// Define STAGE_PERF_CNT_EN to build the saturating bubble/flush counters.
module id_exe_stage_reg
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  freeze_in,
  input  logic                  flush_in,
  input  logic                  hazard_in,
  input  logic                  valid_in,
  input  logic                  wb_en_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  branch_in,
  input  logic                  s_in,
  input  logic [3:0]            exe_cmd_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     val_rn_in,
  input  logic [DATA_W-1:0]     val_rm_in,
  input  logic                  imm_in,
  input  logic [SHIFT_OP_W-1:0] shift_operand_in,
  input  logic [IMM24_W-1:0]    signed_imm24_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  carry_in,
  output logic                  valid_out,
  output logic                  wb_en_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  branch_out,
  output logic                  s_out,
  output logic [3:0]            exe_cmd_out,
  output logic [DATA_W-1:0]     pc_out,
  output logic [DATA_W-1:0]     val_rn_out,
  output logic [DATA_W-1:0]     val_rm_out,
  output logic                  imm_out,
  output logic [SHIFT_OP_W-1:0] shift_operand_out,
  output logic [IMM24_W-1:0]    signed_imm24_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic                  carry_out,
  output logic [CNT_W-1:0]      bubble_cnt_out,
  output logic [CNT_W-1:0]      flush_cnt_out
);

  localparam int unsigned DATA_BUNDLE_W =
      3 * DATA_W + 1 + SHIFT_OP_W + IMM24_W + REG_ADDR_W + 1;

  ctrl_t                     ctrl_in, ctrl_q;
  logic [DATA_BUNDLE_W-1:0]  data_in, data_q;
  logic                      stage_bubble;
  logic                      ctrl_clear;

  // Flush and hazard both squash the whole slot; an invalid ID slot only
  // squashes control so stray operand values never reach a write-back.
  assign stage_bubble = flush_in | hazard_in;
  assign ctrl_clear   = stage_bubble | ~valid_in;

  assign ctrl_in = '{
    valid:     valid_in,
    wb_en:     wb_en_in,
    mem_read:  mem_read_in,
    mem_write: mem_write_in,
    branch:    branch_in,
    s:         s_in,
    exe_cmd:   exe_cmd_in
  };

  assign data_in = {pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
                    signed_imm24_in, dest_in, carry_in};

  pipe_field_reg #(
    .WIDTH   (CTRL_W),
    .CLR_VAL (BUBBLE)
  ) u_ctrl_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .clear (ctrl_clear),
    .hold  (freeze_in),
    .din   (ctrl_in),
    .dout  (ctrl_q)
  );

  pipe_field_reg #(
    .WIDTH   (DATA_BUNDLE_W),
    .CLR_VAL ('0)
  ) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (1'b1),
    .clear (stage_bubble),
    .hold  (freeze_in),
    .din   (data_in),
    .dout  (data_q)
  );

  assign valid_out     = ctrl_q.valid;
  assign wb_en_out     = ctrl_q.wb_en;
  assign mem_read_out  = ctrl_q.mem_read;
  assign mem_write_out = ctrl_q.mem_write;
  assign branch_out    = ctrl_q.branch;
  assign s_out         = ctrl_q.s;
  assign exe_cmd_out   = ctrl_q.exe_cmd;

  assign {pc_out, val_rn_out, val_rm_out, imm_out, shift_operand_out,
          signed_imm24_out, dest_out, carry_out} = data_q;

`ifdef STAGE_PERF_CNT_EN
  logic             bubble_evt, flush_evt;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Flush has priority, so a flushed edge never counts as a hazard bubble.
  assign flush_evt  = ~freeze_in & flush_in;
  assign bubble_evt = ~freeze_in & ~flush_in & (hazard_in | ~valid_in);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bubble_evt && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
    if (flush_evt && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt_out = bubble_cnt_q;
  assign flush_cnt_out  = flush_cnt_q;
`else
  assign bubble_cnt_out = '0;
  assign flush_cnt_out  = '0;
`endif

  // The decoder never issues a valid instruction that both reads and writes memory.
  mem_excl_a : assert property (@(posedge clk) disable iff (!rst_n)
      !(~freeze_in & ~stage_bubble & valid_in & mem_conflict(mem_read_in, mem_write_in)));

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
Pipeline register between the decode/control stage and the execute stage of the ARM-subset core. Captures the decoded control bundle (wb_en, mem_read, mem_write, exe_cmd, branch, s), operand values, immediate fields, destination, PC and carry flag, and presents them to EXE one cycle later. Implements the core's stall, bubble-insertion and flush rules, and tracks an explicit valid bit per slot.

Parameters:
DATA_W, 32, width of PC and operand values
CNT_W, 16, width of the optional performance counters

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
freeze_in  in  1  global stall (memory wait); hold all contents
flush_in  in  1  taken branch in EXE; replace slot with bubble
hazard_in  in  1  RAW hazard detected in ID; load bubble while ID holds
valid_in  in  1  ID slot holds a real instruction
wb_en_in, mem_read_in, mem_write_in, branch_in, s_in  in  1 each  decoded control
exe_cmd_in  in  4  ALU command
pc_in, val_rn_in, val_rm_in  in  DATA_W each  PC+4 and register operands
imm_in  in  1  immediate-operand select
shift_operand_in  in  12  shifter operand field
signed_imm24_in  in  24  branch offset
dest_in  in  4  destination register
carry_in  in  1  status-register C flag for ADC/SBC
*_out (one per input above, same widths), valid_out  out  registered copies
bubble_cnt_out, flush_cnt_out  out  CNT_W each  performance counters

Behaviour:
- Reset (rst_n=0, async): every output 0, valid_out=0, counters 0. Deassertion takes effect on the next rising edge.
- Latency: exactly 1 cycle from input to output. No combinational path from inputs to outputs.
- Priority per rising edge: freeze_in > flush_in > hazard_in > load.
- freeze_in=1: all registers hold, including valid_out and counters. flush_in and hazard_in are ignored; the flush source keeps flush_in asserted until freeze drops.
- flush_in=1 (not frozen): load bubble.
- hazard_in=1 (not frozen, no flush): load bubble.
- Otherwise: load all inputs. If valid_in=0, control fields are forced to bubble values regardless of the control inputs.
- Bubble definition: valid_out=0, wb_en, mem_read, mem_write, branch, s = 0, exe_cmd=4'b0000. Data fields (pc, val_rn, val_rm, imm, shift_operand, signed_imm24, dest, carry) are zeroed.
- Invariant: valid_out=0 implies all control outputs are 0.
- mem_read_in and mem_write_in both 1 on a valid load: both registered as given. The upstream decoder guarantees exclusion; an assertion flags the violation.
- Reset asserted mid-operation: immediate clear, irrespective of freeze.

Optional Feature:
STAGE_PERF_CNT_EN defined:
- bubble_cnt_out increments on each unfrozen edge where a bubble is loaded because of hazard_in or valid_in=0.
- flush_cnt_out increments on each unfrozen edge with flush_in=1.
- Both counters saturate at all-ones and never wrap.

STAGE_PERF_CNT_EN undefined:
- Counter logic is absent and both ports are driven constant 0. The port list is unchanged.

Decomposition:
- Shared package core_pkg:
  - EXE_* command constants: MOV 0001, MVN 1001, ADD 0010, ADC 0011, SUB 0100, SBC 0101, AND 0110, ORR 0111, EOR 1000, NOP 0000.
  - Field widths: SHIFT_OP_W=12, IMM24_W=24, REG_ADDR_W=4.
  - A BUBBLE control constant.
- Sub-module pipe_field_reg: parameterised width, with inputs load, clear, hold and value CLR_VAL. Instantiated once for the control bundle and once for the data bundle.

Test Plan:
- Reset: rst_n low with nonzero inputs -> all outputs 0, valid_out=0. rst_n high, valid ADD (exe_cmd 0010, wb_en 1, dest 3) -> outputs match on the next edge.
- Normal load: STR (mem_write 1, wb_en 0, exe_cmd 0010, val_rn 0x100) -> identical outputs one cycle later, valid_out=1.
- Hazard: hazard_in=1 for one cycle with a valid SUB present -> that cycle outputs bubble. The next cycle loads the SUB; with the feature enabled, bubble_cnt_out=1.
- Flush vs hazard: flush_in=1 and hazard_in=1 together -> bubble. flush_cnt_out increments, bubble_cnt_out does not.
- Freeze: load LDR, then freeze_in=1 for 3 cycles with flush_in=1 and changing inputs -> outputs hold the LDR. Freeze drops with flush still high -> bubble.
- Saturation (feature enabled, CNT_W=4): 20 consecutive flushes -> flush_cnt_out stops at 15.
